pixel_shade_pipe: RTL and testbench

Parametrised fixed-point successor to get_pixel_color. It converts a per-pixel ray hit record (block id, hit face, distance t) into an RGB pixel. It does this through a palette lookup, face-direction shading and distance fog. It sits between the ray/block intersection stage and the frame buffer writer, with full valid/ready backpressure and a runtime-writable colour palette.

---
 rtl/pixel_shade_pipe.sv | 184 ++++++++++++++++++
 tb/tb_pixel_shade_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_shade_pipe.sv
// Three-stage fixed-point pixel shader: palette lookup, face shading, distance fog.
// A single global advance enable gives valid/ready backpressure across all stages.
module pixel_shade_pipe #(
  parameter int CH_W       = 8,
  parameter int NUM_BLOCKS = 12,
  parameter int BID_W      = 4,
  parameter int T_W        = 16,
  parameter int FOG_SHIFT  = 4,
  parameter int FOG_R      = 128,
  parameter int FOG_G      = 128,
  parameter int FOG_B      = 255
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [10:0]         x_in,
  input  logic [9:0]          y_in,
  input  logic                hit_in,
  input  logic [BID_W-1:0]    block_id_in,
  input  logic [2:0]          block_dir_in,
  input  logic [T_W-1:0]      t_in,
  input  logic [1:0]          mode_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic                pal_we_in,
  input  logic [BID_W-1:0]    pal_addr_in,
  input  logic [3*CH_W-1:0]   pal_data_in,
  output logic [10:0]         x_out,
  output logic [9:0]          y_out,
  output logic [CH_W-1:0]     r_out,
  output logic [CH_W-1:0]     g_out,
  output logic [CH_W-1:0]     b_out,
  output logic                valid_out,
  input  logic                ready_in
);

  localparam int PW = CH_W + 9;
  localparam logic [BID_W:0]  NB      = NUM_BLOCKS[BID_W:0];
  localparam logic [CH_W-1:0] FOG_R_C = CH_W'(FOG_R);
  localparam logic [CH_W-1:0] FOG_G_C = CH_W'(FOG_G);
  localparam logic [CH_W-1:0] FOG_B_C = CH_W'(FOG_B);

  typedef logic [CH_W-1:0] ch_t;

  function automatic ch_t scale(input ch_t c, input logic [8:0] k);
    logic [PW-1:0] p;
    p = PW'(c) * PW'(k);
    return ch_t'(p >> 8);
  endfunction

  function automatic ch_t blend(input ch_t c, input ch_t fog, input logic [8:0] f);
    logic [PW-1:0] p;
    p = PW'(c) * PW'(9'd256 - f) + PW'(fog) * PW'(f);
    return ch_t'(p >> 8);
  endfunction

  logic adv;
  assign adv       = !valid_out || ready_in;
  assign ready_out = adv;

  // ---------------- palette ----------------
  logic [3*CH_W-1:0] pal [NUM_BLOCKS];

  // NOTE: the palette must read as zero after reset, so it is built from
  // resettable flops rather than a RAM macro without a reset port.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_BLOCKS; i++) pal[i] <= '0;
    end else if (pal_we_in && ({1'b0, pal_addr_in} < NB)) begin
      pal[pal_addr_in] <= pal_data_in;
    end
  end

  // ---------------- S1 lookup (comb feed) ----------------
  logic              miss;
  logic [3*CH_W-1:0] s1_rgb_d;
  logic [1:0]        s1_mode_d;

  assign miss = !hit_in || !({1'b0, block_id_in} < NB);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s1_rgb_d  = pal[block_id_in];
    s1_mode_d = mode_in;
    // A miss carries the fog colour with shading and fog disabled, which
    // reproduces the fog colour exactly through the later arithmetic.
    if (miss) begin
      s1_rgb_d  = {FOG_R_C, FOG_G_C, FOG_B_C};
      s1_mode_d = 2'b00;
    end
  end

  logic              s1_valid;
  logic [10:0]       s1_x;
  logic [9:0]        s1_y;
  logic [3*CH_W-1:0] s1_rgb;
  logic [2:0]        s1_dir;
  logic [T_W-1:0]    s1_t;
  logic [1:0]        s1_mode;

  // ---------------- S2 shading (comb feed) ----------------
  logic [8:0] k;
  always_comb begin
    k = 9'd256;
    if (s1_mode[0]) begin
      case (s1_dir)
        3'd0, 3'd1: k = 9'd205;
        3'd3:       k = 9'd128;
        3'd4, 3'd5: k = 9'd230;
        default:    k = 9'd256;
      endcase
    end
  end

  ch_t sh_r, sh_g, sh_b;
  assign sh_r = scale(s1_rgb[3*CH_W-1:2*CH_W], k);
  assign sh_g = scale(s1_rgb[2*CH_W-1:CH_W],   k);
  assign sh_b = scale(s1_rgb[CH_W-1:0],        k);

  logic           s2_valid;
  logic [10:0]    s2_x;
  logic [9:0]     s2_y;
  ch_t            s2_r, s2_g, s2_b;
  logic [T_W-1:0] s2_t;
  logic           s2_fog_en;

  // ---------------- S3 fog (comb feed) ----------------
  logic [T_W-1:0] t_sh;
  logic [8:0]     f;
  always_comb begin
    t_sh = s2_t >> FOG_SHIFT;
    f    = (t_sh >= T_W'(256)) ? 9'd256 : t_sh[8:0];
    if (!s2_fog_en) f = 9'd0;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_rgb    <= '0;
      s1_dir    <= '0;
      s1_t      <= '0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_r      <= '0;
      s2_g      <= '0;
      s2_b      <= '0;
      s2_t      <= '0;
      s2_fog_en <= 1'b0;
      valid_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else if (adv) begin
      s1_valid  <= valid_in;
      s1_x      <= x_in;
      s1_y      <= y_in;
      s1_rgb    <= s1_rgb_d;
      s1_dir    <= block_dir_in;
      s1_t      <= t_in;
      s1_mode   <= s1_mode_d;
      s2_valid  <= s1_valid;
      s2_x      <= s1_x;
      s2_y      <= s1_y;
      s2_r      <= sh_r;
      s2_g      <= sh_g;
      s2_b      <= sh_b;
      s2_t      <= s1_t;
      s2_fog_en <= s1_mode[1];
      valid_out <= s2_valid;
      x_out     <= s2_x;
      y_out     <= s2_y;
      r_out     <= blend(s2_r, FOG_R_C, f);
      g_out     <= blend(s2_g, FOG_G_C, f);
      b_out     <= blend(s2_b, FOG_B_C, f);
    end
  end

endmodule

// File: tb/tb_pixel_shade_pipe.sv
// Scoreboard bench for pixel_shade_pipe: directed pixels push expectations,
// a monitor pops and compares on every output transfer.
module tb_pixel_shade_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        hit_in;
  logic [3:0]  block_id_in;
  logic [2:0]  block_dir_in;
  logic [15:0] t_in;
  logic [1:0]  mode_in;
  logic        valid_in;
  logic        ready_out;
  logic        pal_we_in;
  logic [3:0]  pal_addr_in;
  logic [23:0] pal_data_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [7:0]  r_out, g_out, b_out;
  logic        valid_out;
  logic        ready_in;

  pixel_shade_pipe dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .hit_in(hit_in),
    .block_id_in(block_id_in), .block_dir_in(block_dir_in), .t_in(t_in),
    .mode_in(mode_in), .valid_in(valid_in), .ready_out(ready_out),
    .pal_we_in(pal_we_in), .pal_addr_in(pal_addr_in), .pal_data_in(pal_data_in),
    .x_out(x_out), .y_out(y_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [44:0] vec;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic pal_write(input int addr, input int r, input int g, input int b);
    pal_we_in   = 1'b1;
    pal_addr_in = addr[3:0];
    pal_data_in = {r[7:0], g[7:0], b[7:0]};
    @(posedge clk_in); #1;
    pal_we_in   = 1'b0;
  endtask

  // Present one pixel, wait for acceptance, and record its expected output.
  task automatic send(input int id, input int x, input int hit, input int bid,
                      input int dir, input int t, input int mode,
                      input int r, input int g, input int b, input bit lat);
    exp_t e;
    bit   ok = 0;
    x_in = x[10:0]; y_in = 10'(x + 3); hit_in = hit[0]; block_id_in = bid[3:0];
    block_dir_in = dir[2:0]; t_in = t[15:0]; mode_in = mode[1:0]; valid_in = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_in);
      if (ready_out) begin ok = 1; break; end
    end
    if (!ok) begin
      timeout($sformatf("accept_pix%0d", id));
    end else begin
      e.id  = id;
      e.vec = {x[10:0], 10'(x + 3), r[7:0], g[7:0], b[7:0]};
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    mode_in  = 2'b00;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) @(posedge clk_in);
    #1;
    if (sb.size() != 0) timeout($sformatf("drain_%0d_left", sb.size()));
  endtask

  // ---------------- monitor ----------------
  logic [44:0] held;
  bit          stall_prev = 0;

  initial forever begin
    @(negedge clk_in);
    if (rst_in && valid_out) begin
      if (!ready_in) begin
        check("stall_ready_out", ready_out, 0);
        if (stall_prev) check("stall_stable", {x_out, y_out, r_out, g_out, b_out}, held);
        held       = {x_out, y_out, r_out, g_out, b_out};
        stall_prev = 1;
      end else begin
        stall_prev = 0;
        if (sb.size() == 0) begin
          timeout("unexpected_output");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("pix%0d", e.id), {x_out, y_out, r_out, g_out, b_out}, e.vec);
          if (e.lat) check($sformatf("lat_pix%0d", e.id), cyc - e.acc, 3);
        end
      end
    end else begin
      stall_prev = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; pal_we_in = 1'b0;
    pal_addr_in = '0; pal_data_in = '0; x_in = '0; y_in = '0; hit_in = 1'b0;
    block_id_in = '0; block_dir_in = '0; t_in = '0; mode_in = '0;
    #1;
    check("rst_ready_out", ready_out, 1);
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_outputs", {x_out, y_out, r_out, g_out, b_out}, 0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    pal_write(1, 200, 100, 50);
    // shading and fog on palette entry 1 = (200,100,50)
    send( 1,  5, 1, 1, 2,    0, 3, 200, 100,  50, 1);
    send( 2,  6, 1, 1, 3,    0, 3, 100,  50,  25, 1);
    send( 3,  7, 1, 1, 0,    0, 3, 160,  80,  40, 1);
    send( 4,  8, 1, 1, 2, 2048, 3, 164, 114, 152, 1);
    send( 5,  9, 1, 1, 2, 8192, 3, 128, 128, 255, 1);
    send( 6, 10, 1, 1, 2, 8192, 1, 200, 100,  50, 1);
    send( 7, 11, 1, 1, 2, 4096, 3, 128, 128, 255, 1);
    send( 8, 12, 1, 1, 3,    0, 2, 200, 100,  50, 1);
    send( 9, 13, 1, 1, 4,    0, 3, 179,  89,  44, 1);
    send(10, 14, 1, 1, 6,    0, 3, 200, 100,  50, 1);
    // misses and id range edges
    send(11, 15, 0, 1, 2,    0, 3, 128, 128, 255, 1);
    send(12, 16, 1, 13, 2,   0, 3, 128, 128, 255, 1);
    send(13, 17, 1, 12, 2,   0, 3, 128, 128, 255, 1);
    send(14, 18, 1, 11, 2,   0, 3,   0,   0,   0, 1);
    drain(20);

    // write to an entry in the same cycle it is looked up: old value wins
    pal_write(2, 10, 20, 30);
    pal_we_in = 1'b1; pal_addr_in = 4'd2; pal_data_in = {8'd40, 8'd50, 8'd60};
    send(15, 20, 1, 2, 2, 0, 3, 10, 20, 30, 1);
    pal_we_in = 1'b0;
    send(16, 21, 1, 2, 2, 0, 3, 40, 50, 60, 1);
    drain(20);

    // backpressure: 4-cycle stall right after the first output
    fork
      begin
        send(21, 100, 1, 1, 2, 0, 3, 200, 100,  50, 0);
        send(22, 101, 1, 1, 3, 0, 3, 100,  50,  25, 0);
        send(23, 102, 1, 1, 0, 0, 3, 160,  80,  40, 0);
        send(24, 103, 1, 1, 4, 0, 3, 179,  89,  44, 0);
        send(25, 104, 1, 1, 6, 0, 3, 200, 100,  50, 0);
        send(26, 105, 1, 1, 3, 0, 2, 200, 100,  50, 0);
      end
      begin
        bit seen = 0;
        for (int n = 0; n < 20; n++) begin
          @(negedge clk_in);
          if (valid_out) begin seen = 1; break; end
        end
        if (!seen) timeout("bp_first_valid");
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        ready_in = 1'b1;
      end
    join
    drain(30);

    // reset with three pixels in flight
    send(31, 200, 1, 1, 2, 0, 3, 200, 100, 50, 0);
    send(32, 201, 1, 1, 2, 0, 3, 200, 100, 50, 0);
    send(33, 202, 1, 1, 2, 0, 3, 200, 100, 50, 0);
    check("pre_rst_valid_out", valid_out, 1);
    rst_in = 1'b0;
    #1;
    check("mid_rst_valid_out", valid_out, 0);
    check("mid_rst_ready_out", ready_out, 1);
    sb.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    send(34, 300, 1, 1, 2, 0, 3, 0, 0, 0, 1);
    send(35, 301, 1, 2, 0, 0, 3, 0, 0, 0, 1);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
